// File: rtl/fixed_point_normalizer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// fixed_point_normalizer : 2-stage valid/ready sign-bit count + barrel shift
// Revision 1.0
// ============================================================================
module fixed_point_normalizer #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_shift,
  output logic                 out_zero
);
  localparam int SW = $clog2(N);

  logic          s1_v;
  logic          s2_v;
  logic          s2_ready;
  logic [N-1:0]  s1_data;
  logic [SW-1:0] s1_cnt;
  logic          s1_zero;
  logic [N-2:0]  eq_sign;
  logic [SW-1:0] lead_cnt;
  logic          run;
  logic [N-1:0]  stage [SW+1];

  assign s2_ready  = !s2_v || out_ready;
  assign in_ready  = rst_n && (!s1_v || s2_ready);
  assign out_valid = s2_v;

  // Bits matching the sign become ones, so the redundant sign count is a
  // leading-ones count over the lower N-1 bits (max N-1, fits in SW bits).
  assign eq_sign = ~(in_data[N-2:0] ^ {(N-1){in_data[N-1]}});

  always_comb begin
    lead_cnt = '0;
    run      = 1'b1;
    for (int i = N-2; i >= 0; i--) begin
      if (run && eq_sign[i]) begin
        lead_cnt = lead_cnt + SW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_cnt  <= '0;
      s1_zero <= 1'b0;
    end else if (in_ready) begin
      s1_v    <= in_valid;
      s1_data <= in_data;
      s1_cnt  <= lead_cnt;
      s1_zero <= (in_data == '0);
    end
  end

  // Logarithmic barrel shifter: stage k shifts by 2**k when cnt bit k is set.
  assign stage[0] = s1_data;
  for (genvar k = 0; k < SW; k++) begin : g_barrel
    assign stage[k+1] = s1_cnt[k] ? (stage[k] << (2**k)) : stage[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v      <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_zero  <= 1'b0;
    end else if (s2_ready) begin
      s2_v      <= s1_v;
      out_data  <= stage[SW];
      out_shift <= s1_cnt;
      out_zero  <= s1_zero;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_normalizer.sv
`default_nettype none
`timescale 1ns/1ps
// tb_fixed_point_normalizer : directed + randomized checks against a
// shift-until-normalized reference model.
module tb_fixed_point_normalizer;
  localparam int N  = 32;
  localparam int SW = $clog2(N);
  typedef logic [N+SW:0] res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_data;
  logic [SW-1:0] out_shift;
  logic          out_zero;
  res_t          actual;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fixed_point_normalizer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_shift(out_shift), .out_zero(out_zero)
  );

  assign actual = {out_data, out_shift, out_zero};

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid && !out_ready) |=> $stable({out_data, out_shift, out_zero}))
    else begin
      mismatched++;
      $display("FAIL stall_assert: outputs changed while stalled, now %h", actual);
    end

  // Shift left until the top two bits differ, or all N-1 shifts are used.
  function automatic res_t model(input logic [N-1:0] x);
    logic [N-1:0] y;
    int s;
    y = x;
    s = 0;
    while (s < N-1 && y[N-1] == y[N-2]) begin
      y = y << 1;
      s++;
    end
    return {y, SW'(s), (x == '0)};
  endfunction

  function automatic logic [N-1:0] rand_word();
    int k;
    k = $urandom_range(0, N-1);
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return N'($signed($urandom) >>> k);
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if ({out_valid, in_ready, out_data, out_shift, out_zero} !== '0) begin
      mismatched++;
      $display("FAIL reset_state: valid=%0b ready=%0b data=%h shift=%0d zero=%0b, required all 0",
               out_valid, in_ready, out_data, out_shift, out_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: in_ready=%0b, required 1", in_ready);
    end
  endtask

  task automatic test_basic_values();
    logic [N-1:0] vin  [7];
    res_t         vexp [7];
    vin  = '{32'h0000_0001, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFF0,
             32'h0000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    vexp = '{{32'h4000_0000, 5'd30, 1'b0}, {32'h48D1_59E0, 5'd2,  1'b0},
             {32'h8000_0000, 5'd0,  1'b0}, {32'h8000_0000, 5'd27, 1'b0},
             {32'h0000_0000, 5'd31, 1'b1}, {32'h8000_0000, 5'd31, 1'b0},
             {32'h7FFF_FFFF, 5'd0,  1'b0}};
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = (c < 7);
      in_data  = (c < 7) ? vin[c] : '0;
      #1;
      if (c < 7) begin
        compared++;
        if (in_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL basic_in_ready[%0d]: in_ready=%0b, required 1", c, in_ready);
        end
      end
      if (c >= 2 && c < 9) begin
        compared++;
        if (out_valid !== 1'b1 || actual !== vexp[c-2]) begin
          mismatched++;
          $display("FAIL basic_value[%0d]: valid=%0b got %h, required %h",
                   c-2, out_valid, actual, vexp[c-2]);
        end
      end
    end
  endtask

  task automatic test_latency();
    res_t exp;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = rand_word();
    exp      = model(in_data);
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL latency_t: ready=%0b valid=%0b, required 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL latency_t1: ready=%0b valid=%0b, required 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || actual !== exp) begin
      mismatched++;
      $display("FAIL latency_t2: ready=%0b valid=%0b got %h, required 1/1 %h",
               in_ready, out_valid, actual, exp);
    end
    @(negedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL latency_drain: valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] w [4];
    res_t q [$];
    res_t held;
    res_t exp;
    int   acc  = 0;
    int   outs = 0;
    for (int i = 0; i < 4; i++) w[i] = rand_word();
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w[acc];
      #1;
      compared++;
      if (in_ready !== (c < 2)) begin
        mismatched++;
        $display("FAIL bp_in_ready[%0d]: in_ready=%0b, required %0b", c, in_ready, (c < 2));
      end
      if (in_ready) begin
        q.push_back(model(w[acc]));
        acc++;
      end
      if (c == 2) begin
        held = actual;
        compared++;
        if (out_valid !== 1'b1 || actual !== q[0]) begin
          mismatched++;
          $display("FAIL bp_head: valid=%0b got %h, required %h", out_valid, actual, q[0]);
        end
      end
      if (c > 2) begin
        compared++;
        if (out_valid !== 1'b1 || actual !== held) begin
          mismatched++;
          $display("FAIL bp_stable[%0d]: valid=%0b got %h, required %h", c, out_valid, actual, held);
        end
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (acc < 4);
      in_data   = (acc < 4) ? w[acc] : '0;
      #1;
      if (c < 4) begin
        compared++;
        if (out_valid !== 1'b1) begin
          mismatched++;
          $display("FAIL bp_no_bubble[%0d]: valid=%0b, required 1", c, out_valid);
        end
      end
      if (out_valid) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL bp_extra_word: got %h, required none", actual);
        end else begin
          exp = q.pop_front();
          outs++;
          if (actual !== exp) begin
            mismatched++;
            $display("FAIL bp_order[%0d]: got %h, required %h", outs-1, actual, exp);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_data));
        acc++;
      end
    end
    in_valid = 1'b0;
    compared++;
    if (outs != 4 || acc != 4) begin
      mismatched++;
      $display("FAIL bp_count: out=%0d in=%0d, required 4/4", outs, acc);
    end
  endtask

  task automatic test_random();
    res_t q [$];
    res_t held = '0;
    res_t exp;
    int   sent = 0;
    int   recv = 0;
    int   cyc  = 0;
    logic took = 1'b0;
    logic stall_prev = 1'b0;
    in_valid = 1'b0;
    while (recv < 10000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || took) begin
        in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
        in_data  = rand_word();
      end
      #1;
      if (stall_prev) begin
        compared++;
        if (actual !== held || out_valid !== 1'b1) begin
          mismatched++;
          $display("FAIL rand_stall: valid=%0b got %h, required %h", out_valid, actual, held);
        end
      end
      if (out_valid && out_ready) begin
        compared++;
        recv++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL rand_extra_word: got %h, required none", actual);
        end else begin
          exp = q.pop_front();
          if (actual !== exp) begin
            mismatched++;
            $display("FAIL rand_word[%0d]: got %h, required %h", recv-1, actual, exp);
          end
        end
      end
      took = in_valid && in_ready;
      if (took) begin
        q.push_back(model(in_data));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      held       = actual;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    compared++;
    if (recv != 10000 || sent != 10000 || q.size() != 0) begin
      mismatched++;
      $display("FAIL rand_count: sent=%0d recv=%0d left=%0d, required 10000/10000/0",
               sent, recv, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = rand_word();
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_full: valid=%0b ready=%0b, required 1/0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({out_valid, in_ready, out_data, out_shift, out_zero} !== '0) begin
      mismatched++;
      $display("FAIL mid_async_clear: valid=%0b ready=%0b data=%h shift=%0d zero=%0b, required all 0",
               out_valid, in_ready, out_data, out_shift, out_zero);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_release: ready=%0b valid=%0b, required 1/0", in_ready, out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL mid_stale[%0d]: valid=%0b data=%h, required 0", c, out_valid, out_data);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b1 || actual !== {32'h4000_0000, 5'd30, 1'b0}) begin
      mismatched++;
      $display("FAIL mid_next_word: valid=%0b got %h, required 1 %h",
               out_valid, actual, {32'h4000_0000, 5'd30, 1'b0});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_values();
    test_latency();
    test_backpressure();
    test_random();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fixed_point_normalizer.md
# fixed_point_normalizer

Pipelined normalizer for signed two's-complement fixed-point words. It counts redundant sign bits and left-shifts each word so that bit N-2 differs from the sign bit. The count is a leading-ones count on the sign-adjusted word, and the shift is a barrel shift. The block sits directly downstream of the leading-ones counter function and feeds the block-floating-point and divider front ends, which need a normalized mantissa plus an exponent adjustment. It sustains one word per cycle under a valid/ready handshake with full backpressure.

## Interface
- `N`, default 32: data width in bits. Must be a power of two, at least 8.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: block accepts the input word this cycle.
- `in_data` input N: signed two's-complement input word.
- `out_valid` output 1: output word valid.
- `out_ready` input 1: consumer accepts the output word this cycle.
- `out_data` output N: normalized word, `in_data` shifted left by `out_shift`.
- `out_shift` output $clog2(N): redundant sign bit count, range 0..N-1.
- `out_zero` output 1: input word was exactly zero.

## Operation
- Decided: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Transfer rule: a transfer occurs on a rising edge where valid and ready are both 1, on either port.
- Stage S1 (register): captures `in_data` and computes `cnt`.
  - `cnt` = number of leading bits of `in_data[N-2:0]` equal to `in_data[N-1]`.
  - Implement as a leading-ones count of `~(in_data[N-2:0] ^ {N-1{in_data[N-1]}})`, saturating at N-1.
  - Also registers `zero` = (`in_data` == 0).
- Stage S2 (output register):
  - `out_data` = S1 data << `cnt`, with zero fill.
  - `out_shift` = `cnt`.
  - `out_zero` = S1 zero flag.
- Arithmetic rules:
  - The shift never overflows, so the sign is preserved.
  - For nonzero, non-minus-one inputs: `out_data[N-1]` != `out_data[N-2]`.
  - Input 0: result 0, shift N-1, `out_zero`=1.
  - Input -1: result 0x80..0, shift N-1, `out_zero`=0.
- Valid flags: each stage holds a valid flag, `s1_v` and `s2_v`. `out_valid` = `s2_v`.
- Ready chain (combinational):
  - `s2_ready` = !`s2_v` || `out_ready`.
  - `in_ready` = `rst_n` && (!`s1_v` || `s2_ready`).
- Stage advance:
  - S1 loads when `in_ready` is 1. `s1_v` takes `in_valid`.
  - S2 loads when `s2_ready` is 1. `s2_v` takes `s1_v`.
  - A stage that is not loading holds its data and valid flag unchanged.
- No bubbles: with `out_ready` held at 1, throughput is one word per cycle.
- Stall: while `out_valid`=1 and `out_ready`=0, `out_data`, `out_shift` and `out_zero` must remain stable. The S1 word is held. `in_ready` = !`s1_v`.
- Simultaneous drain and fill: when S2 drains and S1 fills on the same edge, both transfers occur and no word is lost or duplicated.
- Ordering: words emerge in acceptance order. There is no reordering and no dropping.
- Reset:
  - `rst_n` low asynchronously clears `s1_v`, `s2_v`, `out_data`, `out_shift` and `out_zero` to 0.
  - `in_ready` = 0 while `rst_n` is low.
  - In-flight words are discarded.
  - After release, `in_ready` = 1 on the first cycle.

## Timing
- Latency: a word accepted on edge t appears on `out_valid`/`out_data` after edge t+1, provided there is no stall.
- Reset values: `out_valid`=0, `out_data`=0, `out_shift`=0, `out_zero`=0, `in_ready`=0.
- Register depth:
  - The combinational path inside S1 is the count only.
  - The combinational path inside S2 is the shift only.
  - No path runs from `in_data` to any output without a register.
- Only `in_ready` depends combinationally on `out_ready`. No output depends combinationally on `in_valid` or `in_data`.
- Capacity: 2 words in flight. After 2 accepted words with `out_ready`=0, `in_ready`=0.

## Test plan
- Basic values (N=32, `out_ready`=1, back-to-back) -> expected (`out_data`, `out_shift`, `out_zero`):
  - 0x0000_0001 -> 0x4000_0000, 30, 0
  - 0x1234_5678 -> 0x48D1_59E0, 2, 0
  - 0x8000_0000 -> 0x8000_0000, 0, 0
  - 0xFFFF_FFF0 -> 0x8000_0000, 27, 0
- Extremes:
  - 0x0000_0000 -> 0x0000_0000, 31, 1
  - 0xFFFF_FFFF -> 0x8000_0000, 31, 0
  - 0x7FFF_FFFF -> 0x7FFF_FFFF, 0, 0
- Backpressure: send 4 words with `out_ready`=0.
  - `in_ready` falls after 2 accepts. `out_data` is stable during the stall.
  - Raising `out_ready` releases all 4 words in order, one per cycle.
- Random throttling: randomize `in_valid`/`out_ready` for 10k words against a reference model.
  - Required: zero mismatches, zero lost or duplicated words, and the stability assertion on stalled outputs never fires.
- Reset mid-stream: assert `rst_n`=0 asynchronously (between edges) with 2 words in flight.
  - All outputs go to 0 immediately and `in_ready`=0.
  - After release, no stale word appears. The next accepted 0x0000_0001 yields 0x4000_0000 / shift 30.
- Latency check: a single word on edge t with idle pipeline -> `out_valid` rises exactly after edge t+1, and `in_ready` stays 1 throughout.
